// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between a
// read-only fetch requester (i_*) and a load/store requester (d_*).
// Each access runs IDLE -> BUSY_I/BUSY_D -> DONE -> IDLE. DONE lasts one
// cycle and carries the granted port's ack pulse. An optional timeout
// aborts a stalled access and reports it on err.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   i_req, i_addr                  fetch request and address
//   i_ack, i_rdata                 fetch ack pulse and read data
//   d_req, d_we, d_addr, d_wdata   load/store request, direction, address, data
//   d_ack, d_rdata                 load/store ack pulse and read data
//   err                            high with the ack of a timed-out access
//   mem_req, mem_we, mem_addr,
//   mem_wdata                      shared memory request (held through BUSY)
//   mem_rdata, mem_rdy             shared memory response
module mem_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t           state_q;
  logic             last_grant_q;  // 0 = fetch, 1 = data
  logic [CNT_W-1:0] cnt_q;

  // Fetch wins when it is alone or when data had the previous grant.
  logic grant_i_c;
  assign grant_i_c = i_req && (!d_req || last_grant_q);

  // Arbitration, memory handshake and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      cnt_q        <= '0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      err          <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_i_c) begin
            state_q      <= BUSY_I;
            last_grant_q <= 1'b0;
            cnt_q        <= '0;
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= i_addr;
            mem_wdata    <= '0;
          end else if (d_req) begin
            state_q      <= BUSY_D;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mem_req      <= 1'b1;
            mem_we       <= d_we;
            mem_addr     <= d_addr;
            mem_wdata    <= d_wdata;
          end
        end
        BUSY_I, BUSY_D: begin
          // A ready in the timeout cycle still counts as success.
          if (mem_rdy) begin
            state_q <= DONE;
            mem_req <= 1'b0;
            if (state_q == BUSY_I) begin
              i_ack   <= 1'b1;
              i_rdata <= mem_rdata;
            end else begin
              d_ack <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end
          end else if (TO_EN && (cnt_q == CNT_LAST)) begin
            state_q <= DONE;
            mem_req <= 1'b0;
            err     <= 1'b1;
            if (state_q == BUSY_I) begin
              i_ack   <= 1'b1;
              i_rdata <= '0;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // Requests are not sampled here; requesters drop req next cycle.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rdy;

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          port;   // 0 = fetch, 1 = data
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_d_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle checks plus scoreboard pop on every ack.
  task automatic monitor();
    exp_t e;
    chk("ack_exclusive", 64'(i_ack & d_ack), 64'(0));
    if (i_ack || d_ack) begin
      chk("sb_has_entry", 64'(sb_q.size() != 0), 64'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("ack_port", 64'(d_ack), 64'(e.port));
        chk("ack_rdata", 64'(e.port ? d_rdata : i_rdata), 64'(e.rdata));
        chk("ack_err", 64'(err), 64'(e.err));
      end
    end else begin
      chk("err_without_ack", 64'(err), 64'(0));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
  endtask

  // One full access from IDLE: request, BUSY checks, ack, release.
  task automatic access(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int waits, input int exp_busy, input bit exp_err);
    exp_t e;
    int   busy;
    bit   got;
    e.port = port;
    e.err  = exp_err;
    if (exp_err)       e.rdata = '0;
    else if (!port)    e.rdata = rdata;
    else if (we)       e.rdata = model_d_rdata;
    else               e.rdata = rdata;
    if (port) model_d_rdata = e.rdata;
    sb_q.push_back(e);
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    step();
    busy = 0;
    got  = 1'b0;
    while (!got && busy < 32) begin
      busy++;
      chk("busy_mem_req", 64'(mem_req), 64'(1));
      chk("busy_mem_addr", 64'(mem_addr), 64'(addr));
      chk("busy_mem_we", 64'(mem_we), 64'(we));
      if (we) chk("busy_mem_wdata", 64'(mem_wdata), 64'(wdata));
      mem_rdy   = (busy == waits + 1);
      mem_rdata = mem_rdy ? rdata : 32'($urandom);
      step();
      got = i_ack | d_ack;
    end
    chk("busy_cycles", 64'(busy), 64'(exp_busy));
    chk("done_mem_req", 64'(mem_req), 64'(0));
    mem_rdy = 1'b0;
    if (port) begin d_req = 1'b0; d_we = 1'b0; end
    else i_req = 1'b0;
    step();
    chk("idle_after_done_ack", 64'(i_ack | d_ack), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_acks", 64'({i_ack, d_ack, err}), 64'(0));
    chk("rst_mem_fields", 64'({mem_we, mem_addr, mem_wdata} == '0), 64'(1));
    chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'(0));
    reset = 1'b0;
    step();

    // Tie after reset: data first, pending fetch served next (zero-wait fetch).
    i_req = 1'b1; i_addr = 32'h0000_3000;
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h1111_1111, 0, 1, 1'b0);
    access(1'b0, 1'b0, 32'h0000_3000, 32'h0, 32'h3C01_0001, 0, 1, 1'b0);

    // Store with 3 wait states, ready in the timeout cycle: success, d_rdata kept.
    access(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h5555_AAAA, 3, 4, 1'b0);

    // Tie after a data grant: fetch first, then data.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0020;
    access(1'b0, 1'b0, 32'h0000_4000, 32'h0, 32'h2222_2222, 1, 2, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h3333_3333, 0, 1, 1'b0);

    // Timeouts on both ports, then ready on the 4th BUSY cycle.
    access(1'b0, 1'b0, 32'h0000_5000, 32'h0, 32'h4444_4444, 100, 4, 1'b1);
    access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h6666_6666, 100, 4, 1'b1);
    access(1'b0, 1'b0, 32'h0000_5004, 32'h0, 32'h7777_7777, 3, 4, 1'b0);

    // mem_rdy outside BUSY has no effect.
    mem_rdy = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    repeat (3) begin
      step();
      chk("idle_rdy_mem_req", 64'(mem_req), 64'(0));
    end
    mem_rdy = 1'b0;
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h8888_8888, 2, 3, 1'b0);

    // Reset in the 2nd BUSY cycle of a fetch; both requests stay held.
    i_req = 1'b1; i_addr = 32'h0000_6000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_7000;
    step();
    chk("pre_rst_busy_addr", 64'(mem_addr), 64'(32'h0000_6000));
    step();
    chk("pre_rst_busy_req", 64'(mem_req), 64'(1));
    reset = 1'b1;
    #1;
    chk("async_rst_mem_req", 64'(mem_req), 64'(0));
    chk("async_rst_fields", 64'({mem_addr, i_rdata, d_rdata} == '0), 64'(1));
    model_d_rdata = '0;
    step();
    reset = 1'b0;
    access(1'b1, 1'b0, 32'h0000_7000, 32'h0, 32'h9999_9999, 1, 2, 1'b0);
    access(1'b0, 1'b0, 32'h0000_6000, 32'h0, 32'hABCD_0123, 0, 1, 1'b0);

    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: memory data width.
REQ-002 SHALL have parameter ADDR_W, default 32: memory address width.
REQ-003 SHALL have parameter TIMEOUT, default 16: max BUSY cycles before abort; 0 disables timeout.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports i_req input 1 (fetch request), i_addr input ADDR_W, i_ack output 1, i_rdata output DATA_W; the fetch port is read-only.
REQ-007 SHALL have ports d_req input 1, d_we input 1, d_addr input ADDR_W, d_wdata input DATA_W, d_ack output 1, d_rdata output DATA_W; this is the load/store port.
REQ-008 SHALL have port err  output  1  pulses with the ack of an aborted (timed-out) access.
REQ-009 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W, mem_rdata input DATA_W, mem_rdy input 1, forming the single shared memory port.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, DONE; all outputs registered.
REQ-011 IDLE: if no req, SHALL stay in IDLE; if exactly one of i_req/d_req is high, SHALL go to that port's BUSY state; if both, SHALL grant the port opposite to last_grant (round-robin).
REQ-012 On grant SHALL latch addr, and for data also we/wdata, into mem_* and set last_grant; mem_req=1 from the first BUSY cycle (one cycle after req was sampled).
REQ-013 BUSY: mem_req, mem_we, mem_addr, mem_wdata SHALL stay constant; requester-side inputs are ignored after the grant.
REQ-014 BUSY with mem_rdy=1: SHALL go to DONE, capture mem_rdata into the granted port's rdata (write: rdata unchanged), and drop mem_req.
REQ-015 DONE: SHALL hold for exactly 1 cycle with the granted port's ack=1, then go to IDLE; ack is a one-cycle pulse.
REQ-016 Latency: req sampled at cycle N, mem_rdy at cycle M>=N+1 -> ack high at cycle M+1; with zero-wait memory (mem_rdy high in first BUSY cycle), ack at N+2.
REQ-017 Each requester SHALL hold req and its request fields until ack, and deassert req in the cycle after ack; the arbiter SHALL ignore req during DONE.
REQ-018 The cycle counter SHALL clear to 0 on entering BUSY and increment on each BUSY cycle with mem_rdy=0.
REQ-019 If TIMEOUT!=0, counter==TIMEOUT-1 and mem_rdy=0: SHALL go to DONE with err=1 alongside ack, rdata=0, mem_req dropped.
REQ-020 If mem_rdy rises in the same cycle the timeout fires, SHALL treat it as success (err=0, data captured).
REQ-021 mem_rdy while not in BUSY SHALL be ignored.
REQ-022 The counter width SHALL be sized to hold TIMEOUT-1 without wrap.
REQ-023 i_ack and d_ack SHALL never be high in the same cycle; mem_req SHALL never be high outside BUSY.

Reset
REQ-024 reset SHALL immediately force state=IDLE, last_grant=fetch, counter=0, and every output including mem_req, acks, err, mem_we, mem_addr, mem_wdata, i_rdata, and d_rdata to 0.
REQ-025 Reset mid-BUSY SHALL abort the access with no ack; after release, pending reqs SHALL be arbitrated as fresh requests, with data winning a tie because last_grant=fetch.

Verification
REQ-026 Single fetch: i_req, i_addr=0x00003000, 1-cycle-later mem_rdy with mem_rdata=0x3C010001 -> mem_req 1 cycle, i_ack pulse, i_rdata=0x3C010001, d_ack=0.
REQ-027 Tie after reset: i_req and d_req high at the same edge -> data served first, fetch second, then on the next tie fetch first (alternation).
REQ-028 Store: d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF, 3 wait cycles -> mem_we=1 and fields stable for 4 BUSY cycles, d_ack at the cycle after mem_rdy, d_rdata unchanged.
REQ-029 Timeout: TIMEOUT=4, mem_rdy held 0 -> mem_req high exactly 4 cycles, then ack+err for 1 cycle, rdata=0; mem_rdy on the 4th cycle -> err=0.
REQ-030 Reset mid-access: assert reset in the 2nd BUSY cycle -> mem_req drops asynchronously, no ack; after release, the held d_req is re-granted.
